// File: rtl/llc_tag_array_if.sv
// Request/response bundle between the LLC command decoder and the tag array.
interface llc_tag_array_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WAY_W     = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [ADDR_SIZE-1:0] req_addr;
  logic                 req_shared;
  logic                 resp_valid;
  logic                 resp_hit;
  logic [WAY_W-1:0]     resp_way;
  logic [1:0]           resp_state;
  logic                 resp_evict;
  logic                 resp_evict_dirty;
  logic [ADDR_SIZE-1:0] resp_evict_addr;
  logic                 resp_hitm;

  modport master (
    output req_valid, req_op, req_addr, req_shared,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_state,
           resp_evict, resp_evict_dirty, resp_evict_addr, resp_hitm
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_shared,
    output req_ready, resp_valid, resp_hit, resp_way, resp_state,
           resp_evict, resp_evict_dirty, resp_evict_addr, resp_hitm
  );
endinterface

// File: rtl/llc_tag_array.sv
// N-way set-associative LLC tag/MESI store with per-set tree PLRU.
// One request in flight: IDLE accept -> LOOKUP (tag compare) -> UPDATE (write + response).
module llc_tag_array #(
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_BYTES = 64,
  parameter int NUM_SETS   = 16384,
  parameter int N_WAY      = 16
) (
  input  logic             clk,
  input  logic             rst,
  llc_tag_array_if.slave   bus
);
  localparam int OFFSET_SIZE = $clog2(LINE_BYTES);
  localparam int INDEX_SIZE  = $clog2(NUM_SETS);
  localparam int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
  localparam int WAY_W       = $clog2(N_WAY);
  localparam logic [INDEX_SIZE-1:0] LAST_SET = INDEX_SIZE'(NUM_SETS - 1);

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [2:0] OP_READ = 3'd0, OP_WRITE = 3'd1, OP_SNP_READ = 3'd2,
                         OP_SNP_RWIM = 3'd3, OP_SNP_INVAL = 3'd4, OP_CLEAR = 3'd5;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_UPDATE} fsm_e;

  // Storage arrays carry no reset: INIT sweeps every set before any lookup.
  logic [N_WAY-1:0][TAG_SIZE-1:0] tag_q  [NUM_SETS];
  logic [N_WAY-1:0][1:0]          st_q   [NUM_SETS];
  logic [N_WAY-2:0]               plru_q [NUM_SETS];

  fsm_e                              fsm_q, fsm_d;
  logic [INDEX_SIZE-1:0]             init_idx_q, init_idx_d;
  logic                              clear_q, clear_d;
  logic [2:0]                        op_q;
  logic [ADDR_SIZE-1:OFFSET_SIZE]    addr_q;
  logic                              shared_q;
  logic                              hit_q;
  logic [WAY_W-1:0]                  hway_q, vway_q;
  logic [1:0]                        hst_q, vst_q;
  logic [TAG_SIZE-1:0]               vtag_q;

  logic [INDEX_SIZE-1:0] idx;
  logic [TAG_SIZE-1:0]   tag_in;
  assign idx    = addr_q[OFFSET_SIZE +: INDEX_SIZE];
  assign tag_in = addr_q[ADDR_SIZE-1 -: TAG_SIZE];

  function automatic logic [WAY_W-1:0] plru_victim(input logic [N_WAY-2:0] p);
    logic [WAY_W-1:0] node, way;
    logic             b;
    node = '0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b                 = p[node];
      way[WAY_W-1-l]    = b;
      node              = (node << 1) + WAY_W'(1) + WAY_W'(b);
    end
    return way;
  endfunction

  // Each node on the path to w is flipped to point at the other subtree.
  function automatic logic [N_WAY-2:0] plru_touch(input logic [N_WAY-2:0] p,
                                                  input logic [WAY_W-1:0] w);
    logic [WAY_W-1:0] node;
    logic             b;
    node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b       = w[WAY_W-1-l];
      p[node] = ~b;
      node    = (node << 1) + WAY_W'(1) + WAY_W'(b);
    end
    return p;
  endfunction

  // Lookup: hit detection and victim choice for the latched index.
  logic                           hit_c, inv_found;
  logic [WAY_W-1:0]               hway_c, inv_way, vway_c;
  logic [N_WAY-1:0][TAG_SIZE-1:0] set_tag;
  logic [N_WAY-1:0][1:0]          set_st;

  always_comb begin
    set_tag   = tag_q[idx];
    set_st    = st_q[idx];
    hit_c     = 1'b0;
    hway_c    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = N_WAY - 1; w >= 0; w--) begin
      if (set_st[w] == ST_I) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (set_st[w] != ST_I && set_tag[w] == tag_in) begin
        hit_c  = 1'b1;
        hway_c = WAY_W'(w);
      end
    end
    vway_c = inv_found ? inv_way : plru_victim(plru_q[idx]);
  end

  wire accept = (fsm_q == S_IDLE) && bus.req_valid;

  always_comb begin
    fsm_d      = fsm_q;
    init_idx_d = init_idx_q;
    clear_d    = clear_q;
    case (fsm_q)
      S_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_SET) begin
          fsm_d   = S_IDLE;
          clear_d = 1'b0;
        end
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == OP_CLEAR) begin
            fsm_d   = S_INIT;
            clear_d = 1'b1;
          end else begin
            fsm_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: fsm_d = S_UPDATE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= S_INIT;
      init_idx_q <= '0;
      clear_q    <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      shared_q   <= 1'b0;
      hit_q      <= 1'b0;
      hway_q     <= '0;
      vway_q     <= '0;
      hst_q      <= ST_I;
      vst_q      <= ST_I;
      vtag_q     <= '0;
    end else begin
      fsm_q      <= fsm_d;
      init_idx_q <= init_idx_d;
      clear_q    <= clear_d;
      if (accept) begin
        op_q     <= bus.req_op;
        addr_q   <= bus.req_addr[ADDR_SIZE-1:OFFSET_SIZE];
        shared_q <= bus.req_shared;
      end
      if (fsm_q == S_LOOKUP) begin
        hit_q  <= hit_c;
        hway_q <= hway_c;
        hst_q  <= set_st[hway_c];
        vway_q <= vway_c;
        vst_q  <= set_st[vway_c];
        vtag_q <= set_tag[vway_c];
      end
    end
  end

  // Update stage: response fields and array write controls.
  logic             we_st, we_tag, we_plru;
  logic [WAY_W-1:0] upd_way;
  logic [1:0]       upd_st;

  always_comb begin
    bus.req_ready        = (fsm_q == S_IDLE);
    bus.resp_valid       = (fsm_q == S_UPDATE) ||
                           ((fsm_q == S_INIT) && clear_q && (init_idx_q == LAST_SET));
    bus.resp_hit         = 1'b0;
    bus.resp_way         = '0;
    bus.resp_state       = ST_I;
    bus.resp_evict       = 1'b0;
    bus.resp_evict_dirty = 1'b0;
    bus.resp_evict_addr  = '0;
    bus.resp_hitm        = 1'b0;
    we_st                = 1'b0;
    we_tag               = 1'b0;
    we_plru              = 1'b0;
    upd_way              = '0;
    upd_st               = ST_I;
    if (fsm_q == S_UPDATE) begin
      case (op_q)
        OP_READ, OP_WRITE: begin
          upd_way = hit_q ? hway_q : vway_q;
          if (op_q == OP_WRITE) upd_st = ST_M;
          else if (hit_q)       upd_st = hst_q;
          else                  upd_st = shared_q ? ST_S : ST_E;
          we_st   = 1'b1;
          we_tag  = !hit_q;
          we_plru = 1'b1;
          bus.resp_hit   = hit_q;
          bus.resp_way   = upd_way;
          bus.resp_state = upd_st;
          if (!hit_q && vst_q != ST_I) begin
            bus.resp_evict       = 1'b1;
            bus.resp_evict_dirty = (vst_q == ST_M);
            bus.resp_evict_addr  = {vtag_q, idx, {OFFSET_SIZE{1'b0}}};
          end
        end
        OP_SNP_READ, OP_SNP_RWIM, OP_SNP_INVAL: begin
          if (hit_q) begin
            upd_way        = hway_q;
            upd_st         = (op_q == OP_SNP_READ) ? ST_S : ST_I;
            we_st          = 1'b1;
            bus.resp_hit   = 1'b1;
            bus.resp_way   = hway_q;
            bus.resp_state = upd_st;
            bus.resp_hitm  = (op_q != OP_SNP_INVAL) && (hst_q == ST_M);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fsm_q == S_INIT) begin
      tag_q[init_idx_q]  <= '0;
      st_q[init_idx_q]   <= '0;
      plru_q[init_idx_q] <= '0;
    end else begin
      if (we_st)   st_q[idx][upd_way]  <= upd_st;
      if (we_tag)  tag_q[idx][upd_way] <= tag_in;
      if (we_plru) plru_q[idx]         <= plru_touch(plru_q[idx], upd_way);
    end
  end
endmodule

// File: tb/tb_llc_tag_array.sv
// Directed bench for llc_tag_array: 4 ways, 4 sets, 64-byte lines.
module tb_llc_tag_array;
  localparam int AW = 32;
  localparam logic [2:0] RD = 3'd0, WR = 3'd1, SRD = 3'd2, SRWIM = 3'd3,
                         SINV = 3'd4, CLR = 3'd5, NOP = 3'd6;
  localparam int I = 0, S = 1, E = 2, M = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llc_tag_array_if #(.ADDR_SIZE(AW), .WAY_W(2)) bus ();

  llc_tag_array #(.ADDR_SIZE(AW), .LINE_BYTES(64), .NUM_SETS(4), .N_WAY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int          r_lat;
  logic        r_hit, r_ev, r_dirty, r_hitm;
  logic [1:0]  r_way, r_st;
  logic [31:0] r_eaddr;

  task automatic count_ready(output int n);
    n = 0;
    while (!bus.req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] addr, input logic sh);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.req_shared = sh;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_op     = NOP;
    bus.req_addr   = 32'hdead_beef;
    bus.req_shared = 1'b0;
    r_lat = 0;
    do begin
      @(negedge clk);
      r_lat++;
    end while (!bus.resp_valid && r_lat < 20);
    if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    r_hit   = bus.resp_hit;
    r_way   = bus.resp_way;
    r_st    = bus.resp_state;
    r_ev    = bus.resp_evict;
    r_dirty = bus.resp_evict_dirty;
    r_eaddr = bus.resp_evict_addr;
    r_hitm  = bus.resp_hitm;
  endtask

  task automatic exp_resp(input string t, input int lat, input int hit, input int way,
                          input int st, input int ev, input int dirty, input int eaddr,
                          input int hitm);
    chk({t, ".lat"},   r_lat,   lat);
    chk({t, ".hit"},   r_hit,   hit);
    chk({t, ".way"},   r_way,   way);
    chk({t, ".state"}, r_st,    st);
    chk({t, ".evict"}, r_ev,    ev);
    chk({t, ".dirty"}, r_dirty, dirty);
    chk({t, ".eaddr"}, r_eaddr, eaddr);
    chk({t, ".hitm"},  r_hitm,  hitm);
  endtask

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_op     = NOP;
    bus.req_addr   = '0;
    bus.req_shared = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ready", bus.req_ready, 0);
    chk("rst.resp_valid", bus.resp_valid, 0);
    chk("rst.evict_addr", bus.resp_evict_addr, 0);
    rst = 1'b1;
    #1;
    count_ready(n);
    chk("init_cycles", n, 4);

    // set 0 fill and PLRU victim selection
    req(RD, 32'h000, 0); exp_resp("rd0_miss", 2, 0, 0, E, 0, 0, 0, 0);
    req(RD, 32'h000, 0); exp_resp("rd0_hit",  2, 1, 0, E, 0, 0, 0, 0);
    req(RD, 32'h100, 0); exp_resp("rd1",      2, 0, 1, E, 0, 0, 0, 0);
    req(RD, 32'h200, 0); exp_resp("rd2",      2, 0, 2, E, 0, 0, 0, 0);
    req(RD, 32'h300, 0); exp_resp("rd3",      2, 0, 3, E, 0, 0, 0, 0);
    req(WR, 32'h100, 0); exp_resp("wr1_hit",  2, 1, 1, M, 0, 0, 0, 0);
    req(RD, 32'h400, 0); exp_resp("rd4_evict", 2, 0, 2, E, 1, 0, 32'h200, 0);
    req(SINV, 32'h400, 0); exp_resp("sinv4",  2, 1, 2, I, 0, 0, 0, 0);
    req(RD, 32'h500, 1); exp_resp("rd5_shared", 2, 0, 2, S, 0, 0, 0, 0);
    req(RD, 32'h600, 0); exp_resp("rd6_evict", 2, 0, 0, E, 1, 0, 32'h000, 0);
    req(RD, 32'h700, 0); exp_resp("rd7_evict", 2, 0, 3, E, 1, 0, 32'h300, 0);
    req(RD, 32'h800, 0); exp_resp("rd8_dirty", 2, 0, 1, E, 1, 1, 32'h100, 0);
    req(SRD, 32'h900, 0); exp_resp("srd_miss", 2, 0, 0, I, 0, 0, 0, 0);
    req(NOP, 32'h123, 1); exp_resp("nop",      2, 0, 0, I, 0, 0, 0, 0);

    // snoop transitions on set 1
    req(WR, 32'h040, 0);    exp_resp("wr40",     2, 0, 0, M, 0, 0, 0, 0);
    req(SRD, 32'h040, 0);   exp_resp("srd40",    2, 1, 0, S, 0, 0, 0, 1);
    req(SRWIM, 32'h040, 0); exp_resp("srwim40",  2, 1, 0, I, 0, 0, 0, 0);
    req(RD, 32'h040, 0);    exp_resp("rd40",     2, 0, 0, E, 0, 0, 0, 0);

    // fill set 1 with M lines, then CLEAR
    req(WR, 32'h040, 0); exp_resp("wm0", 2, 1, 0, M, 0, 0, 0, 0);
    req(WR, 32'h140, 0); exp_resp("wm1", 2, 0, 1, M, 0, 0, 0, 0);
    req(WR, 32'h240, 0); exp_resp("wm2", 2, 0, 2, M, 0, 0, 0, 0);
    req(WR, 32'h340, 0); exp_resp("wm3", 2, 0, 3, M, 0, 0, 0, 0);
    req(CLR, 32'h0, 0);  exp_resp("clear", 4, 0, 0, I, 0, 0, 0, 0);
    req(RD, 32'h140, 0); exp_resp("rd140_post_clr", 2, 0, 0, E, 0, 0, 0, 0);

    // reset while the request sits in LOOKUP
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = RD;
    bus.req_addr  = 32'h140;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst.resp_valid0", bus.resp_valid, 0);
    @(negedge clk);
    chk("midrst.resp_valid1", bus.resp_valid, 0);
    chk("midrst.ready", bus.req_ready, 0);
    rst = 1'b1;
    #1;
    count_ready(n);
    chk("reinit_cycles", n, 4);
    req(RD, 32'h140, 0); exp_resp("rd140_post_rst", 2, 0, 0, E, 0, 0, 0, 0);
    req(RD, 32'h800, 0); exp_resp("rd800_post_rst", 2, 0, 0, E, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
